// File: rtl/usb_host_pkg.sv
// rtl/usb_host_pkg.sv - shared UART timing constant and receiver state encoding
package usb_host_pkg;

    localparam int BAUD_DIV_1M = 48;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W:0]  wptr;
    logic [ADDR_W:0]  rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty = (wptr == rptr);
    assign level = wptr - rptr;

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Head is forced to zero when empty so the output is defined out of reset.
    assign rd_data = empty ? '0 : mem[rptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a byte FIFO stream
module uart_rx_fifo
    import usb_host_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_1M,
    parameter int ADDR_W   = 4
) (
    input  logic              clk_i,
    input  logic              rstn,
    input  logic              rxd_i,
    output logic [7:0]        m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [ADDR_W:0]   level_o,
    output logic              frame_err_o,
    output logic              overflow_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             baud_half;
    logic             baud_wrap;
    logic             cnt_clr;
    logic             shift_en;
    logic             stop_ok;
    logic             stop_bad;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rx_s    <= rx_meta;
        end
    end

    assign baud_half = (baud_cnt == HALF_LAST);
    assign baud_wrap = (baud_cnt == FULL_LAST);

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (baud_half) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (baud_wrap && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (baud_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving STOP at the stop-bit centre lets the next start edge be caught early.
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE:  cnt_clr = 1'b1;
            START: cnt_clr = baud_half;
            DATA: begin
                cnt_clr  = baud_wrap;
                shift_en = baud_wrap;
            end
            STOP: begin
                cnt_clr  = baud_wrap;
                stop_ok  = baud_wrap && rx_s;
                stop_bad = baud_wrap && !rx_s;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    assign m_valid_o = !fifo_empty;
    assign pop       = m_valid_o && m_ready_i;
    assign drop      = stop_ok && fifo_full && !pop;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            frame_err_o <= stop_bad;
            overflow_o  <= drop;
        end
    end

    sync_fifo #(
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn    (rstn),
        .wr_en   (stop_ok),
        .wr_data (shreg),
        .rd_en   (m_ready_i),
        .rd_data (m_data_o),
        .level   (level_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int BAUD   = 48;
    localparam int ADDR_W = 4;

    logic              clk_i = 1'b0;
    logic              rstn = 1'b0;
    logic              rxd_i = 1'b1;
    logic              m_ready_i = 1'b0;
    logic [7:0]        m_data_o;
    logic              m_valid_o;
    logic [ADDR_W:0]   level_o;
    logic              frame_err_o;
    logic              overflow_o;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int both_cnt = 0;
    logic [7:0] got_q[$];

    uart_rx_fifo #(.BAUD_DIV(BAUD), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rstn        (rstn),
        .rxd_i       (rxd_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rstn) begin
            if (frame_err_o) ferr_cnt++;
            if (overflow_o) ovf_cnt++;
            if (frame_err_o && overflow_o) both_cnt++;
            if (m_valid_o && m_ready_i) got_q.push_back(m_data_o);
        end
    end

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rxd_i = f[i];
            repeat (BAUD) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rxd_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int n);
        m_ready_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
        m_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", m_data_o); end
        checks++; if (frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", frame_err_o, overflow_o); end
        rstn = 1'b1;
        idle(5);
    endtask

    task automatic test_single_byte();
        int cnt;
        cnt = 0;
        got_q.delete();
        fork
            drive_frame(8'hA5, 1'b1, 10);
            begin
                while (m_valid_o !== 1'b1 && cnt < 600) begin
                    @(posedge clk_i);
                    #1;
                    cnt++;
                end
            end
        join
        checks++; if (cnt != 459) begin errors++; $display("FAIL single_latency got=%0d exp=459", cnt); end
        checks++; if (m_data_o !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", m_data_o); end
        checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level_o); end
        drain(1);
        checks++; if (m_valid_o !== 1'b0 || level_o !== 5'd0) begin errors++; $display("FAIL single_pop got=%b/%0d exp=0/0", m_valid_o, level_o); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_popcnt got=%0d exp=1", got_q.size()); end
        else if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_popdata got=%h exp=a5", got_q[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        int f0;
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
        f0 = ferr_cnt;
        got_q.delete();
        for (int i = 0; i < 3; i++) drive_frame(seq[i], 1'b1, 10);
        idle(5);
        checks++; if (level_o !== 5'd3) begin errors++; $display("FAIL b2b_level got=%0d exp=3", level_o); end
        drain(3);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== seq[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], seq[i]); end
        end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        rxd_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        idle(600);
        checks++; if (level_o !== 5'd0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL glitch_push got=%0d exp=0", level_o); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_framing();
        int f0, o0;
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        drive_frame(8'h3C, 1'b0, 10);
        idle(600);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_count got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL frame_level got=%0d exp=0", level_o); end
        checks++; if (ovf_cnt != o0) begin errors++; $display("FAIL frame_ovf got=%0d exp=0", ovf_cnt - o0); end
    endtask

    task automatic test_overflow();
        int o0;
        o0 = ovf_cnt;
        got_q.delete();
        for (int i = 0; i < 17; i++) drive_frame(8'(i), 1'b1, 10);
        idle(5);
        checks++; if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL ovf_count got=%0d exp=1", ovf_cnt - o0); end
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", level_o); end
        drain(16);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, got_q[i], 8'(i)); end
        end
    endtask

    task automatic test_overflow_pop();
        int o0;
        o0 = ovf_cnt;
        got_q.delete();
        for (int i = 0; i < 16; i++) drive_frame(8'(i), 1'b1, 10);
        fork
            drive_frame(8'h10, 1'b1, 10);
            begin
                repeat (458) @(posedge clk_i);
                #1;
                m_ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                m_ready_i = 1'b0;
            end
        join
        idle(5);
        checks++; if (ovf_cnt != o0) begin errors++; $display("FAIL ovfpop_ovf got=%0d exp=0", ovf_cnt - o0); end
        checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL ovfpop_level got=%0d exp=16", level_o); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ovfpop_popcnt got=%0d exp=1", got_q.size()); end
        got_q.delete();
        drain(16);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL ovfpop_drain got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovfpop_data[%0d] got=%h exp=%h", i, got_q[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_push_pop_level1();
        got_q.delete();
        drive_frame(8'h11, 1'b1, 10);
        checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL l1_pre_level got=%0d exp=1", level_o); end
        fork
            drive_frame(8'h22, 1'b1, 10);
            begin
                repeat (458) @(posedge clk_i);
                #1;
                m_ready_i = 1'b1;
                checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h11) begin errors++; $display("FAIL l1_before got=%b/%h exp=1/11", m_valid_o, m_data_o); end
                @(posedge clk_i);
                #1;
                m_ready_i = 1'b0;
                checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h22) begin errors++; $display("FAIL l1_after got=%b/%h exp=1/22", m_valid_o, m_data_o); end
                checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL l1_level got=%0d exp=1", level_o); end
            end
        join
        drain(1);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL l1_count got=%0d exp=2", got_q.size()); end
        else if (got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin errors++; $display("FAIL l1_order got=%h,%h exp=11,22", got_q[0], got_q[1]); end
    endtask

    task automatic test_async_reset();
        int f0;
        drive_frame(8'h61, 1'b1, 10);
        drive_frame(8'h62, 1'b1, 10);
        checks++; if (level_o !== 5'd2) begin errors++; $display("FAIL ares_queued got=%0d exp=2", level_o); end
        drive_frame(8'h81, 1'b1, 5);
        rxd_i = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0 || level_o !== 5'd0) begin errors++; $display("FAIL ares_immediate got=%b/%0d exp=0/0", m_valid_o, level_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL ares_data got=%h exp=00", m_data_o); end
        rxd_i = 1'b1;
        @(posedge clk_i);
        #1;
        rstn = 1'b1;
        f0 = ferr_cnt;
        got_q.delete();
        idle(50);
        drive_frame(8'h42, 1'b1, 10);
        idle(5);
        checks++; if (level_o !== 5'd1 || m_data_o !== 8'h42) begin errors++; $display("FAIL ares_rx got=%0d/%h exp=1/42", level_o, m_data_o); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL ares_ferr got=%0d exp=0", ferr_cnt - f0); end
        drain(1);
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic done;
        int f0, o0;
        done = 1'b0;
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        got_q.delete();
        for (int i = 0; i < 8; i++) sent.push_back(8'($urandom));
        fork
            begin
                foreach (sent[i]) drive_frame(sent[i], 1'b1, 10);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i);
                    #1;
                    m_ready_i = 1'($urandom_range(0, 1));
                end
                m_ready_i = 1'b0;
            end
            begin
                logic pv, pr;
                logic [7:0] pd;
                pv = 1'b0; pr = 1'b0; pd = 8'h00;
                while (!done) begin
                    @(negedge clk_i);
                    if (pv && !pr && m_valid_o) begin
                        checks++; if (m_data_o !== pd) begin errors++; $display("FAIL rand_stall got=%h exp=%h", m_data_o, pd); end
                    end
                    pv = m_valid_o; pr = m_ready_i; pd = m_data_o;
                end
            end
        join
        #1;
        drain(10);
        checks++; if (got_q.size() != sent.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== sent[i]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], sent[i]); end
        end
        checks++; if (ferr_cnt != f0 || ovf_cnt != o0) begin errors++; $display("FAIL rand_pulses got=%0d/%0d exp=0/0", ferr_cnt - f0, ovf_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overflow();
        test_overflow_pop();
        test_push_pop_level1();
        test_async_reset();
        test_random();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulses_exclusive got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
